// File: rtl/acq_trk_handoff_pkg.sv
// Shared definitions for the B1 acquisition-to-tracking handoff path.
// Default widths are also used by the acquisition and PRN generator blocks.
package acq_trk_handoff_pkg;

  localparam int ACC_WIDTH_DEF     = 32;
  localparam int PRN_PHS_WIDTH_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_EOP = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_TRACK    = 3'd3,
    ST_REACQ    = 3'd4
  } state_t;

endpackage

// File: rtl/acq_trk_handoff_epoch_cnt.sv
// Epoch counter with clear, epoch-qualified increment and a terminal-count flag.
// The tc flag is valid in the same cycle as the TERM-th qualified epoch.
module acq_trk_handoff_epoch_cnt #(
  parameter int TERM = 10,
  localparam int CW  = $clog2(TERM + 1)
) (
  input  logic rx_clk,
  input  logic rx_rst,
  input  logic clr,
  input  logic en,
  input  logic rx_trk_eop,
  output logic tc
);

  logic [CW-1:0] cnt;
  logic          inc;

  assign inc = en & rx_trk_eop;
  assign tc  = inc && (cnt == CW'(TERM - 1));

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acq_trk_handoff.sv
// Acquisition-to-tracking handoff controller: captures the acquired code phase,
// loads it into tracking on an epoch boundary and restarts acquisition on loss of lock.
module acq_trk_handoff
  import acq_trk_handoff_pkg::*;
#(
  parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
  parameter int PRN_PHS_WIDTH = PRN_PHS_WIDTH_DEF,
  parameter int PHS_OFS       = 0,
  parameter int SETTLE_MS     = 10,
  parameter int LOSS_MS       = 50,
  parameter int EOP_TMO       = 262143,
  parameter int ACQ_RST_CYC   = 4
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     rx_acq_suc,
  input  logic [PRN_PHS_WIDTH-1:0] rx_acq_phs,
  input  logic                     rx_trk_eop,
  input  logic                     rx_lock_ind,
  output logic [ACC_WIDTH-1:0]     tx_init_phs,
  output logic                     tx_init_vld,
  output logic                     tx_trk_en,
  output logic                     tx_acq_rst,
  output logic [2:0]               tx_state,
  output logic [7:0]               tx_reacq_cnt
);

  localparam int TW = $clog2(EOP_TMO + 1);
  localparam int RW = $clog2(ACQ_RST_CYC + 1);

  state_t                   state;
  logic [PRN_PHS_WIDTH-1:0] phs_cap;
  logic [TW-1:0]            tmo;
  logic [RW-1:0]            rst_cnt;
  logic                     settle_tc;
  logic                     miss_tc;
  logic                     tmo_hit;
  logic                     go_reacq;

  assign tx_state = state;
  assign tmo_hit  = (tmo == TW'(EOP_TMO - 1));
  // An epoch arriving on the timeout cycle takes priority over the timeout.
  assign go_reacq = ((state == ST_WAIT_EOP) && !rx_trk_eop && tmo_hit) ||
                    ((state == ST_TRACK) && miss_tc);

  acq_trk_handoff_epoch_cnt #(.TERM(SETTLE_MS)) u_settle_cnt (
    .rx_clk     (rx_clk),
    .rx_rst     (rx_rst),
    .clr        ((state == ST_WAIT_EOP) && rx_trk_eop),
    .en         (state == ST_SETTLE),
    .rx_trk_eop (rx_trk_eop),
    .tc         (settle_tc)
  );

  acq_trk_handoff_epoch_cnt #(.TERM(LOSS_MS)) u_miss_cnt (
    .rx_clk     (rx_clk),
    .rx_rst     (rx_rst),
    .clr        (((state == ST_SETTLE) && settle_tc) ||
                 ((state == ST_TRACK) && rx_trk_eop && rx_lock_ind)),
    .en         ((state == ST_TRACK) && !rx_lock_ind),
    .rx_trk_eop (rx_trk_eop),
    .tc         (miss_tc)
  );

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state        <= ST_IDLE;
      phs_cap      <= '0;
      tmo          <= '0;
      rst_cnt      <= '0;
      tx_init_phs  <= '0;
      tx_init_vld  <= 1'b0;
      tx_trk_en    <= 1'b0;
      tx_acq_rst   <= 1'b0;
      tx_reacq_cnt <= '0;
    end else begin
      tx_init_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_trk_en  <= 1'b0;
          tx_acq_rst <= 1'b0;
          if (rx_acq_suc) begin
            phs_cap <= rx_acq_phs + PRN_PHS_WIDTH'(PHS_OFS);
            tmo     <= '0;
            state   <= ST_WAIT_EOP;
          end
        end
        ST_WAIT_EOP: begin
          if (rx_trk_eop) begin
            tx_init_phs <= {phs_cap, {(ACC_WIDTH - PRN_PHS_WIDTH){1'b0}}};
            tx_init_vld <= 1'b1;
            tx_trk_en   <= 1'b1;
            state       <= ST_SETTLE;
          end else if (!tmo_hit) begin
            tmo <= tmo + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_tc) begin
            state <= ST_TRACK;
          end
        end
        ST_TRACK: begin
        end
        ST_REACQ: begin
          if (rst_cnt == RW'(ACQ_RST_CYC - 1)) begin
            tx_acq_rst <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        default: begin
          tx_trk_en  <= 1'b0;
          tx_acq_rst <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase

      if (go_reacq) begin
        state      <= ST_REACQ;
        tx_trk_en  <= 1'b0;
        tx_acq_rst <= 1'b1;
        rst_cnt    <= '0;
        if (tx_reacq_cnt != 8'hFF) begin
          tx_reacq_cnt <= tx_reacq_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/acq_trk_handoff.md
# acq_trk_handoff

Acquisition-to-tracking handoff controller for the B1 data channel. Sits directly downstream of the BOC acquisition block: captures its success flag and code phase, converts the phase into a 32-bit initial phase word for the tracking PRN generator, and loads it on a tracking epoch boundary. It then supervises the tracking lock indicator and, on sustained loss of lock, restarts acquisition.

## Interface
Parameters:
- ACC_WIDTH, 32, width of the tracking PRN phase accumulator word
- PRN_PHS_WIDTH, 12, width of the acquisition code-phase index
- PHS_OFS, 0, latency compensation added to the captured phase, in PRN_PHS_WIDTH units
- SETTLE_MS, 10, epochs with tracking enabled before lock is supervised
- LOSS_MS, 50, consecutive unlocked epochs that declare loss of lock
- EOP_TMO, 262143, cycles allowed in WAIT_EOP before forced re-acquisition
- ACQ_RST_CYC, 4, cycles that tx_acq_rst is held high

Ports:
- rx_clk  in  1  sole clock
- rx_rst  in  1  synchronous, active-high reset
- rx_acq_suc  in  1  acquisition success, level, sticky until acquisition is reset
- rx_acq_phs  in  PRN_PHS_WIDTH  acquired code phase, valid while rx_acq_suc=1
- rx_trk_eop  in  1  one-cycle tracking PRN epoch pulse
- rx_lock_ind  in  1  tracking lock indicator, sampled on rx_trk_eop
- tx_init_phs  out  ACC_WIDTH  initial phase word for the tracking PRN generator
- tx_init_vld  out  1  one-cycle load strobe for tx_init_phs
- tx_trk_en  out  1  tracking loops enabled
- tx_acq_rst  out  1  reset request to the acquisition block
- tx_state  out  3  current state encoding
- tx_reacq_cnt  out  8  saturating count of re-acquisitions

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE=0, WAIT_EOP=1, SETTLE=2, TRACK=3, REACQ=4. Other codes unreachable; they return to IDLE.
- IDLE: tx_trk_en=0. On rx_acq_suc=1, register phs_cap = (rx_acq_phs + PHS_OFS) mod 2^PRN_PHS_WIDTH and go to WAIT_EOP.
- WAIT_EOP: tmo counter increments each cycle. On rx_trk_eop: tx_init_phs <= {phs_cap, (ACC_WIDTH-PRN_PHS_WIDTH) zeros}, tx_init_vld pulses, and the state goes to SETTLE. If tmo reaches EOP_TMO first, go to REACQ. If rx_trk_eop and the timeout coincide, rx_trk_eop wins.
- SETTLE: tx_trk_en=1. Count rx_trk_eop pulses; at the SETTLE_MS-th pulse, clear the miss counter and go to TRACK. rx_lock_ind is ignored in this state.
- TRACK: tx_trk_en=1. On each rx_trk_eop:
  - rx_lock_ind=1 clears miss.
  - rx_lock_ind=0 increments miss.
  - When miss reaches LOSS_MS, go to REACQ.
- REACQ: tx_trk_en=0 and tx_acq_rst=1 for exactly ACQ_RST_CYC cycles. tx_reacq_cnt increments once on entry and saturates at 255. Then go to IDLE.
- rx_acq_suc is ignored outside IDLE.
- tx_init_phs holds its last loaded value until the next load.
- Miss and settle counters are wide enough for their parameters. They clear on entry to SETTLE and TRACK respectively.

## Timing
- Reset values: tx_init_phs=0, tx_init_vld=0, tx_trk_en=0, tx_acq_rst=0, tx_state=0 (IDLE), tx_reacq_cnt=0. All internal counters are 0.
- All outputs are registered.
- rx_acq_suc high in cycle N gives tx_state=1 in N+1.
- rx_trk_eop in WAIT_EOP at cycle N gives tx_init_vld=1 and the new tx_init_phs in N+1, with tx_trk_en=1 and tx_state=2 in N+1.
- The SETTLE_MS-th epoch at cycle N gives tx_state=3 in N+1.
- The LOSS_MS-th miss epoch at cycle N gives tx_state=4, tx_acq_rst=1 and tx_trk_en=0 in N+1. tx_acq_rst stays high in cycles N+1 through N+ACQ_RST_CYC, and tx_state=0 in N+ACQ_RST_CYC+1.
- rx_rst mid-operation aborts any state, including a pending init strobe or an active tx_acq_rst, and returns all outputs to their reset values on the next edge. tx_reacq_cnt is also cleared.

## Structure
- Shared package holds:
  - the state encodings (IDLE…REACQ, 3 bits)
  - ACC_WIDTH and PRN_PHS_WIDTH defaults, shared with the acquisition and PRN generator blocks
- One natural sub-module, epoch_cnt: a parameterised counter with clear, rx_trk_eop-qualified increment, and a terminal-count flag. It is instantiated for both the settle and miss counting.
- The FSM, phase formatting and timeout counter stay in the top level.

## Test plan
- Reset, then rx_acq_suc=1 with rx_acq_phs=0x123 and PHS_OFS=0, then rx_trk_eop 5 cycles later -> one-cycle tx_init_vld with tx_init_phs=0x12300000, tx_trk_en=1, tx_state=2.
- Wrap-around: PHS_OFS=2 with rx_acq_phs=0xFFF -> tx_init_phs=0x00100000.
- SETTLE_MS=10, then LOSS_MS=50 epochs with rx_lock_ind=0 -> the state sequence below, with tx_acq_rst high exactly 4 cycles and tx_reacq_cnt=1:
  - tx_state 2→3 after the 10th epoch
  - 3→4 after the 50th miss epoch
  - 4→0 after 4 cycles
- In TRACK, feed 49 misses, one locked epoch, then 49 misses -> no REACQ; tx_state remains 3.
- No rx_trk_eop for EOP_TMO cycles in WAIT_EOP -> REACQ entered; tx_init_vld never asserted.
- Assert rx_rst during REACQ, and separately 1 cycle before an expected tx_init_vld -> all outputs at reset values the next cycle, with no strobe and no residual tx_acq_rst.
